// File: rtl/rail_booking_engine.sv
// Seat reservation engine for a small rail network: per-seat segment occupancy,
// first-fit all-or-nothing booking and single-seat cancellation.
module rail_booking_engine #(
    parameter int NUM_TRAINS   = 4,
    parameter int NUM_SEATS    = 10,
    parameter int NUM_STNS     = 5,
    parameter int FARE_PER_SEG = 50,
    localparam int TID_W  = (NUM_TRAINS > 1) ? $clog2(NUM_TRAINS) : 1,
    localparam int STN_W  = 3,
    localparam int SEAT_W = 4,
    localparam int CNT_W  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             op,
    input  logic [TID_W-1:0]                 train_id,
    input  logic [STN_W-1:0]                 src,
    input  logic [STN_W-1:0]                 dest,
    input  logic [CNT_W-1:0]                 num_tickets,
    input  logic [SEAT_W-1:0]                cancel_seat,
    output logic                             done,
    output logic                             success,
    output logic [1:0]                       err_code,
    output logic [CNT_W-1:0]                 booked_count,
    output logic [NUM_SEATS*SEAT_W-1:0]      booked_seats,
    output logic [9:0]                       fare,
    output logic [15:0]                      total_fare,
    output logic [NUM_TRAINS*NUM_SEATS-1:0]  seat_status
);
    localparam int NSEG  = NUM_STNS - 1;
    localparam int NCELL = NUM_TRAINS * NUM_SEATS;

    typedef enum logic [2:0] {IDLE, VALIDATE, SCAN, COMMIT, DONE} state_t;
    state_t state, state_nx;

    logic                             op_q;
    logic [TID_W-1:0]                 tid_q;
    logic [STN_W-1:0]                 src_q, dest_q;
    logic [CNT_W-1:0]                 num_q;
    logic [SEAT_W-1:0]                cseat_q;
    logic [SEAT_W-1:0]                scan_seat;
    logic [CNT_W-1:0]                 cand_cnt, cnt_after;
    logic [NUM_SEATS-1:0][SEAT_W-1:0] cand;
    logic [NUM_SEATS-1:0]             cand_bits;
    logic [NCELL-1:0][NSEG-1:0]       occ, occ_nx;
    logic [NCELL-1:0]                 status_nx;
    logic [NSEG-1:0]                  rmask, scan_mask, cancel_mask;
    logic [9:0]                       fare_calc;
    logic                             invalid, seat_free, commit_ok;

    assign req_ready = (state == IDLE);
    assign done      = (state == DONE);

    always_comb begin
        rmask = '0;
        for (int j = 0; j < NSEG; j++)
            if (j >= int'(src_q) && j < int'(dest_q)) rmask[j] = 1'b1;
    end

    // Only meaningful for valid routes; the invalid path reports zero instead.
    assign fare_calc = 10'((int'(dest_q) - int'(src_q)) * FARE_PER_SEG);

    assign invalid = (int'(tid_q) >= NUM_TRAINS) || (src_q >= dest_q) ||
                     (int'(dest_q) >= NUM_STNS) ||
                     (!op_q && (num_q == '0 || int'(num_q) > NUM_SEATS)) ||
                     (op_q && int'(cseat_q) >= NUM_SEATS);

    always_comb begin
        scan_mask   = '0;
        cancel_mask = '0;
        for (int t = 0; t < NUM_TRAINS; t++)
            for (int s = 0; s < NUM_SEATS; s++)
                if (int'(tid_q) == t) begin
                    if (int'(scan_seat) == s) scan_mask   = occ[t*NUM_SEATS+s];
                    if (int'(cseat_q) == s)   cancel_mask = occ[t*NUM_SEATS+s];
                end
    end

    assign seat_free = ~|(scan_mask & rmask);
    assign cnt_after = cand_cnt + CNT_W'(seat_free);
    assign commit_ok = op_q ? ((cancel_mask & rmask) == rmask) : (cand_cnt == num_q);

    always_comb begin
        occ_nx = occ;
        if (state == COMMIT && commit_ok)
            for (int t = 0; t < NUM_TRAINS; t++)
                for (int s = 0; s < NUM_SEATS; s++)
                    if (int'(tid_q) == t) begin
                        if (!op_q && cand_bits[s])
                            occ_nx[t*NUM_SEATS+s] = occ[t*NUM_SEATS+s] | rmask;
                        if (op_q && int'(cseat_q) == s)
                            occ_nx[t*NUM_SEATS+s] = occ[t*NUM_SEATS+s] & ~rmask;
                    end
        for (int i = 0; i < NCELL; i++) status_nx[i] = |occ_nx[i];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (req_valid) state_nx = VALIDATE;
            VALIDATE: state_nx = invalid ? DONE : (op_q ? COMMIT : SCAN);
            SCAN:     if (cnt_after == num_q || scan_seat == SEAT_W'(NUM_SEATS - 1))
                          state_nx = COMMIT;
            COMMIT:   state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            occ          <= '0;
            seat_status  <= '0;
            op_q         <= 1'b0;
            tid_q        <= '0;
            src_q        <= '0;
            dest_q       <= '0;
            num_q        <= '0;
            cseat_q      <= '0;
            scan_seat    <= '0;
            cand_cnt     <= '0;
            cand         <= '0;
            cand_bits    <= '0;
            success      <= 1'b0;
            err_code     <= 2'd0;
            booked_count <= '0;
            booked_seats <= '0;
            fare         <= '0;
            total_fare   <= '0;
        end else begin
            state       <= state_nx;
            occ         <= occ_nx;
            seat_status <= status_nx;
            case (state)
                IDLE: if (req_valid) begin
                    op_q      <= op;
                    tid_q     <= train_id;
                    src_q     <= src;
                    dest_q    <= dest;
                    num_q     <= num_tickets;
                    cseat_q   <= cancel_seat;
                    scan_seat <= '0;
                    cand_cnt  <= '0;
                    cand      <= '0;
                    cand_bits <= '0;
                end
                VALIDATE: if (invalid) begin
                    success      <= 1'b0;
                    err_code     <= 2'd1;
                    booked_count <= '0;
                    booked_seats <= '0;
                    fare         <= '0;
                    total_fare   <= '0;
                end
                SCAN: begin
                    scan_seat <= scan_seat + SEAT_W'(1);
                    if (seat_free) begin
                        cand_cnt <= cnt_after;
                        for (int k = 0; k < NUM_SEATS; k++)
                            if (k == int'(cand_cnt)) cand[k] <= scan_seat;
                        for (int s = 0; s < NUM_SEATS; s++)
                            if (s == int'(scan_seat)) cand_bits[s] <= 1'b1;
                    end
                end
                COMMIT: begin
                    fare <= fare_calc;
                    if (commit_ok) begin
                        success  <= 1'b1;
                        err_code <= 2'd0;
                        if (op_q) begin
                            booked_count <= CNT_W'(1);
                            booked_seats <= {{((NUM_SEATS-1)*SEAT_W){1'b0}}, cseat_q};
                            total_fare   <= 16'(fare_calc);
                        end else begin
                            booked_count <= num_q;
                            booked_seats <= cand;
                            total_fare   <= 16'(int'(fare_calc) * int'(num_q));
                        end
                    end else begin
                        success      <= 1'b0;
                        err_code     <= op_q ? 2'd3 : 2'd2;
                        booked_count <= '0;
                        booked_seats <= '0;
                        total_fare   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
